pb_io_port_bank: RTL and testbench

//  Parametrised PicoBlaze (kcpsm6) I/O port bank for the Basys3 top levels. Replaces per-design

---
 rtl/pb_io_pkg.sv | 16 +
 rtl/pb_sync2.sv | 24 ++
 rtl/pb_io_port_bank.sv | 135 +++++++++++++
 tb/tb_pb_io_port_bank.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pb_io_pkg.sv
// pb_io_pkg: shared state encodings and default port map for the kcpsm6 I/O port bank
package pb_io_pkg;

    typedef enum logic [1:0] {
        IO_IDLE     = 2'd0,
        IO_ASSERT   = 2'd1,
        IO_SERVICED = 2'd2
    } io_state_t;

    localparam logic [7:0] DEF_IN_BASE   = 8'h00;
    localparam logic [7:0] DEF_OUT_BASE  = 8'h02;
    localparam logic [7:0] DEF_STAT_PORT = 8'h10;
    localparam logic [7:0] DEF_MASK_PORT = 8'h11;
    localparam logic [7:0] DEF_OUT_RST   = 8'h00;

endpackage

// File: rtl/pb_sync2.sv
// pb_sync2: two-flop synchroniser for asynchronous board inputs
module pb_sync2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // first stage may go metastable; second stage gives the clean copy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pb_io_port_bank.sv
// pb_io_port_bank: kcpsm6 port decode with synchronised inputs, read-back outputs and change interrupt
module pb_io_port_bank
    import pb_io_pkg::*;
#(
    parameter int         NUM_IN    = 2,
    parameter int         NUM_OUT   = 2,
    parameter logic [7:0] IN_BASE   = DEF_IN_BASE,
    parameter logic [7:0] OUT_BASE  = DEF_OUT_BASE,
    parameter logic [7:0] STAT_PORT = DEF_STAT_PORT,
    parameter logic [7:0] MASK_PORT = DEF_MASK_PORT,
    parameter logic [7:0] OUT_RST   = DEF_OUT_RST
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           port_id,
    input  logic [7:0]           out_port,
    input  logic                 write_strobe,
    input  logic                 read_strobe,
    output logic [7:0]           in_port,
    output logic                 interrupt,
    input  logic                 interrupt_ack,
    input  logic [8*NUM_IN-1:0]  raw_in,
    output logic [8*NUM_OUT-1:0] dout
);

    localparam logic [7:0] VALID = 8'((16'd1 << NUM_IN) - 16'd1);

    logic [8*NUM_IN-1:0] sync, prev;
    logic [7:0]          chg, pending, mask;
    logic [7:0]          dreg [NUM_OUT];
    logic                req;
    logic                unused;
    io_state_t           state;

    if (NUM_IN < 1 || NUM_IN > 8 || NUM_OUT < 1 || NUM_OUT > 8) begin : g_bad_size
        $error("pb_io_port_bank: NUM_IN and NUM_OUT must be 1..8");
    end
    if (STAT_PORT == MASK_PORT) begin : g_bad_stat
        $error("pb_io_port_bank: STAT_PORT overlaps MASK_PORT");
    end
    for (genvar i = 0; i < NUM_IN; i++) begin : g_chk_in
        for (genvar j = 0; j < NUM_OUT; j++) begin : g_o
            if (8'(IN_BASE + i) == 8'(OUT_BASE + j)) begin : g_e
                $error("pb_io_port_bank: input port overlaps output port");
            end
        end
        if (8'(IN_BASE + i) == STAT_PORT || 8'(IN_BASE + i) == MASK_PORT) begin : g_e
            $error("pb_io_port_bank: input port overlaps status/mask port");
        end
    end
    for (genvar j = 0; j < NUM_OUT; j++) begin : g_chk_out
        if (8'(OUT_BASE + j) == STAT_PORT || 8'(OUT_BASE + j) == MASK_PORT) begin : g_e
            $error("pb_io_port_bank: output port overlaps status/mask port");
        end
        assign dout[8*j +: 8] = dreg[j];
    end

    // reads are side-effect free, so the strobe carries no information here
    assign unused = read_strobe;
    assign req    = |(pending & mask);

    pb_sync2 #(.WIDTH(8*NUM_IN)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (raw_in),
        .q     (sync)
    );

    // previous synchronised sample for per-byte change detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) prev <= '0;
        else       prev <= sync;
    end

    // one change flag per input byte; unimplemented bytes never flag
    always_comb begin
        chg = '0;
        for (int i = 0; i < NUM_IN; i++) chg[i] = |(sync[8*i +: 8] ^ prev[8*i +: 8]);
    end

    // pending is write-1-to-clear with a fresh change taking priority; mask keeps only real bytes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
            mask    <= '0;
        end else begin
            pending <= ((write_strobe && port_id == STAT_PORT) ? pending & ~out_port : pending) | chg;
            if (write_strobe && port_id == MASK_PORT) mask <= out_port & VALID;
        end
    end

    // output byte registers loaded by kcpsm6 OUTPUT instructions
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < NUM_OUT; j++) dreg[j] <= OUT_RST;
        end else begin
            for (int j = 0; j < NUM_OUT; j++)
                if (write_strobe && port_id == 8'(OUT_BASE + j)) dreg[j] <= out_port;
        end
    end

    // combinational read mux onto kcpsm6 in_port; unmapped addresses read zero
    always_comb begin
        in_port = 8'h00;
        for (int i = 0; i < NUM_IN; i++) if (port_id == 8'(IN_BASE + i)) in_port = sync[8*i +: 8];
        for (int j = 0; j < NUM_OUT; j++) if (port_id == 8'(OUT_BASE + j)) in_port = dreg[j];
        if (port_id == STAT_PORT) in_port = pending;
        if (port_id == MASK_PORT) in_port = mask;
    end

    // interrupt handshake: hold level until ack, then wait for the ISR to drain pending
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IO_IDLE;
            interrupt <= 1'b0;
        end else begin
            case (state)
                IO_IDLE: if (req) begin
                    state     <= IO_ASSERT;
                    interrupt <= 1'b1;
                end
                IO_ASSERT: if (interrupt_ack) begin
                    state     <= IO_SERVICED;
                    interrupt <= 1'b0;
                end
                IO_SERVICED: if (!req) state <= IO_IDLE;
                default: begin
                    state     <= IO_IDLE;
                    interrupt <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pb_io_port_bank.sv
// tb_pb_io_port_bank: directed and randomised checks of the port bank against a history-based model
module tb_pb_io_port_bank;

    logic        clk = 1'b0, reset = 1'b1, run = 1'b0;
    logic [7:0]  port_id = 8'h00, out_port = 8'h00, in_port;
    logic        write_strobe = 1'b0, read_strobe = 1'b0, interrupt_ack = 1'b0, interrupt;
    logic [15:0] raw_in = 16'h0000, dout;

    logic [7:0]  port_id2 = 8'h00, out_port2 = 8'h00, in_port2, dout2;
    logic        write_strobe2 = 1'b0, interrupt_ack2 = 1'b0, interrupt2;
    logic [31:0] raw_in2 = 32'h0;

    int vectors = 0, miscompares = 0;

    logic [15:0] hist [3];
    logic [15:0] m_dout;
    logic [7:0]  m_pend, m_mask;
    int          m_st;
    logic        m_irq;

    pb_io_port_bank dut (
        .clk(clk), .reset(reset), .port_id(port_id), .out_port(out_port),
        .write_strobe(write_strobe), .read_strobe(read_strobe), .in_port(in_port),
        .interrupt(interrupt), .interrupt_ack(interrupt_ack), .raw_in(raw_in), .dout(dout)
    );

    pb_io_port_bank #(.NUM_IN(4), .NUM_OUT(1), .OUT_BASE(8'h20)) dut2 (
        .clk(clk), .reset(reset), .port_id(port_id2), .out_port(out_port2),
        .write_strobe(write_strobe2), .read_strobe(read_strobe), .in_port(in_port2),
        .interrupt(interrupt2), .interrupt_ack(interrupt_ack2), .raw_in(raw_in2), .dout(dout2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        port_id = a; out_port = d; write_strobe = 1'b1;
        cyc();
        write_strobe = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string nm);
        port_id = a;
        #1 chk(nm, in_port, exp);
    endtask

    task automatic wr2(input logic [7:0] a, input logic [7:0] d);
        port_id2 = a; out_port2 = d; write_strobe2 = 1'b1;
        cyc();
        write_strobe2 = 1'b0;
    endtask

    task automatic rd2(input logic [7:0] a, input logic [7:0] exp, input string nm);
        port_id2 = a;
        #1 chk(nm, in_port2, exp);
    endtask

    // 0 idle, 1 interrupt asserted, 2 serviced and waiting for pending to drain
    function automatic int fsm_next(input int st, input logic rq, input logic ack);
        return st == 0 ? (rq ? 1 : 0) : st == 1 ? (ack ? 2 : 1) : (rq ? 2 : 0);
    endfunction

    // hist[1] is what in_port shows for inputs; a byte differing between hist[1] and hist[2] flags pending
    function automatic logic [7:0] mrd(input logic [7:0] pid);
        case (pid)
            8'h00:   return hist[1][7:0];
            8'h01:   return hist[1][15:8];
            8'h02:   return m_dout[7:0];
            8'h03:   return m_dout[15:8];
            8'h10:   return m_pend;
            8'h11:   return m_mask;
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            hist[0] <= '0; hist[1] <= '0; hist[2] <= '0;
            m_dout <= '0; m_pend <= '0; m_mask <= '0; m_st <= 0; m_irq <= 1'b0;
        end else begin
            hist[0] <= raw_in; hist[1] <= hist[0]; hist[2] <= hist[1];
            m_pend <= ((write_strobe && port_id == 8'h10) ? m_pend & ~out_port : m_pend)
                      | {6'b0, hist[1][15:8] != hist[2][15:8], hist[1][7:0] != hist[2][7:0]};
            if (write_strobe && port_id == 8'h11) m_mask <= out_port & 8'h03;
            if (write_strobe && port_id == 8'h02) m_dout[7:0] <= out_port;
            if (write_strobe && port_id == 8'h03) m_dout[15:8] <= out_port;
            m_st  <= fsm_next(m_st, |(m_pend & m_mask), interrupt_ack);
            m_irq <= fsm_next(m_st, |(m_pend & m_mask), interrupt_ack) == 1;
        end
    end

    always @(negedge clk) begin
        #4;
        if (run && !reset) begin
            chk("model_dout", dout, m_dout);
            chk("model_interrupt", interrupt, m_irq);
            chk("model_in_port", in_port, mrd(port_id));
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] ports [8];
        ports = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h10, 8'h11, 8'hFF};
        cyc(2);
        #1 chk("reset_dout", dout, 16'h0000);
        chk("reset_interrupt", interrupt, 1'b0);
        reset = 1'b0;
        run = 1'b1;
        cyc();

        wr(8'h02, 8'hA5);
        wr(8'h03, 8'h3C);
        chk("out_dout", dout, 16'h3CA5);
        rd(8'h03, 8'h3C, "out_readback3");
        wr(8'h05, 8'h77);
        chk("out_unmapped", dout, 16'h3CA5);
        rd(8'h02, 8'hA5, "out_readback2");
        cyc();

        raw_in = 16'h12F0; port_id = 8'h00;
        cyc();
        rd(8'h00, 8'h00, "sync_one_edge");
        cyc();
        rd(8'h00, 8'hF0, "sync_byte0");
        rd(8'h01, 8'h12, "sync_byte1");
        rd(8'h10, 8'h00, "pend_two_edges");
        cyc();
        rd(8'h10, 8'h03, "pend_three_edges");
        cyc();

        wr(8'h10, 8'hFF);
        wr(8'h11, 8'h01);
        rd(8'h10, 8'h00, "pend_cleared");
        raw_in = 16'h12F1;
        cyc(3);
        rd(8'h10, 8'h01, "irq_pending");
        chk("irq_not_yet", interrupt, 1'b0);
        cyc();
        chk("irq_assert", interrupt, 1'b1);
        interrupt_ack = 1'b1;
        cyc();
        interrupt_ack = 1'b0;
        chk("irq_ack", interrupt, 1'b0);
        cyc(2);
        chk("irq_serviced", interrupt, 1'b0);
        wr(8'h10, 8'h01);
        chk("irq_after_clear", interrupt, 1'b0);
        cyc();
        raw_in = 16'h13F1;
        repeat (5) begin
            cyc();
            chk("irq_masked_byte", interrupt, 1'b0);
        end
        rd(8'h10, 8'h02, "pend_masked_byte");
        raw_in = 16'h13F0;
        cyc(4);
        chk("irq_reentry", interrupt, 1'b1);
        interrupt_ack = 1'b1;
        cyc();
        interrupt_ack = 1'b0;
        wr(8'h10, 8'hFF);
        cyc();

        raw_in = 16'h13F1;
        cyc(2);
        port_id = 8'h10; out_port = 8'h01; write_strobe = 1'b1;
        cyc();
        write_strobe = 1'b0;
        rd(8'h10, 8'h01, "collision_set_wins");
        wr(8'h11, 8'h00);
        chk("mask_clear_hold0", interrupt, 1'b1);
        cyc();
        chk("mask_clear_hold1", interrupt, 1'b1);
        interrupt_ack = 1'b1;
        cyc();
        interrupt_ack = 1'b0;
        chk("mask_clear_ack", interrupt, 1'b0);
        wr(8'h10, 8'hFF);
        cyc();

        wr(8'h11, 8'h03);
        raw_in = 16'h0000;
        cyc(4);
        chk("pre_reset_irq", interrupt, 1'b1);
        rd(8'h10, 8'h03, "pre_reset_stat");
        #1 reset = 1'b1;
        #1 chk("midrun_reset_dout", dout, 16'h0000);
        chk("midrun_reset_irq", interrupt, 1'b0);
        chk("midrun_reset_stat", in_port, 8'h00);
        cyc();
        reset = 1'b0;
        cyc();

        raw_in2 = 32'h44332211;
        cyc(2);
        rd2(8'h00, 8'h11, "p2_in0");
        rd2(8'h01, 8'h22, "p2_in1");
        rd2(8'h02, 8'h33, "p2_in2");
        rd2(8'h03, 8'h44, "p2_in3");
        wr2(8'h20, 8'h5A);
        chk("p2_dout", dout2, 8'h5A);
        rd2(8'h20, 8'h5A, "p2_readback");
        rd2(8'h10, 8'h0F, "p2_pend_upper0");
        rd2(8'h21, 8'h00, "p2_unmapped");
        wr2(8'h11, 8'hFF);
        rd2(8'h11, 8'h0F, "p2_mask_upper0");
        cyc();

        repeat (3000) begin
            port_id = ($urandom_range(0, 7) == 0) ? 8'($urandom) : ports[$urandom_range(0, 7)];
            out_port = 8'($urandom);
            write_strobe = ($urandom_range(0, 2) == 0);
            interrupt_ack = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 9) == 0) raw_in = 16'($urandom);
            if ($urandom_range(0, 699) == 0) begin
                #1 reset = 1'b1;
                cyc();
                reset = 1'b0;
            end else begin
                cyc();
            end
        end
        write_strobe = 1'b0;
        interrupt_ack = 1'b0;
        cyc();
        run = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
